// File: rtl/data_mem_ctrl_pkg.sv
// Shared definitions for the data memory controller.
// Holds the FSM state encoding, the access-size encoding, the requester
// count, and the alignment rule applied when a request is granted.
package data_mem_ctrl_pkg;

  // Requester 0 = core load/store unit, requester 1 = loader/debug port.
  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_MERGE  = 2'b10,
    ST_RESP   = 2'b11
  } state_e;

  // Encoding 2'b11 is not a member and is treated as an illegal size.
  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10
  } size_e;

  // True when the access cannot be performed: an illegal size, or a
  // half/word access that is not naturally aligned.
  function automatic logic access_bad(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = off[0];
      SIZE_WORD: bad = |off;
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/data_mem_ctrl_lane.sv
// mem_lane_unit: combinational byte/half lane logic for 32-bit words.
// Ports:
//   word_in     - memory word (live read data on loads, captured word on merge)
//   offset      - byte offset within the word (addr[1:0])
//   size        - access size (byte/half/word)
//   is_unsigned - zero-extend (1) or sign-extend (0) on loads
//   wdata       - right-aligned store data
//   ld_data     - selected lane, extended to 32 bits
//   st_word     - word_in with the target lane(s) replaced by wdata
module mem_lane_unit
  import data_mem_ctrl_pkg::*;
(
  input  logic [31:0] word_in,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic [31:0] st_word
);

  logic [4:0]  bit_off;
  logic [31:0] shifted;

  assign bit_off = {offset, 3'b000};
  assign shifted = word_in >> bit_off;

  // Half accesses reaching here are aligned, so bit_off is 0 or 16.
  always_comb begin
    ld_data = word_in;
    st_word = word_in;
    case (size)
      SIZE_BYTE: begin
        ld_data = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
        st_word[bit_off +: 8] = wdata[7:0];
      end
      SIZE_HALF: begin
        ld_data = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
        st_word[bit_off +: 16] = wdata[15:0];
      end
      default: begin
        ld_data = word_in;
        st_word = wdata;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: two-requester data memory controller.
// Arbitrates round-robin between the core LSU (req 0) and the loader/debug
// port (req 1), performs aligned byte/half/word loads with extension, word
// stores directly, and sub-word stores as read-modify-write.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   req_*             - per-requester valid/ready handshake and request fields
//   rsp_valid/err/rdata - one-hot completion pulse with error flag and load data
//   mem_we/a/wd       - word-aligned write port to the data memory
//   mem_rd            - combinational read data for mem_a
// The lane logic assumes DATA_WIDTH = 32.
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
)(
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [NUM_REQ-1:0]                    req_valid,
  output logic [NUM_REQ-1:0]                    req_ready,
  input  logic [NUM_REQ-1:0]                    req_we,
  input  logic [NUM_REQ-1:0][1:0]               req_size,
  input  logic [NUM_REQ-1:0]                    req_unsigned,
  input  logic [NUM_REQ-1:0][ADDRESS_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]                    rsp_valid,
  output logic                                  rsp_err,
  output logic [DATA_WIDTH-1:0]                 rsp_rdata,
  output logic                                  mem_we,
  output logic [ADDRESS_WIDTH-1:0]              mem_a,
  output logic [DATA_WIDTH-1:0]                 mem_wd,
  input  logic [DATA_WIDTH-1:0]                 mem_rd
);

  // Request captured at grant; requester inputs are ignored afterwards.
  typedef struct packed {
    logic                     owner;
    logic                     we;
    logic [1:0]               size;
    logic                     is_unsigned;
    logic                     err;
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]    wdata;
  } txn_t;

  state_e                   state, state_nxt;
  txn_t                     txn;
  logic                     rr_ptr;   // requester favoured on the next contested grant
  logic                     gnt_idx;
  logic                     grant;
  logic [DATA_WIDTH-1:0]    rdata_q;  // extended load result, zero otherwise
  logic [DATA_WIDTH-1:0]    old_q;    // word read in ACCESS for sub-word merge
  logic [DATA_WIDTH-1:0]    lane_word, lane_ld, lane_st;
  logic [ADDRESS_WIDTH-1:0] word_addr;
  logic                     sub_store;

  assign gnt_idx   = req_valid[rr_ptr] ? rr_ptr : ~rr_ptr;
  assign grant     = (state == ST_IDLE) && !rst && (|req_valid);
  assign word_addr = {txn.addr[ADDRESS_WIDTH-1:2], 2'b00};
  assign sub_store = txn.we && !txn.err && (txn.size != SIZE_WORD);

  // ACCESS feeds the live read data (load extract); MERGE feeds the word
  // captured in ACCESS so the write does not depend on mem_rd a second time.
  assign lane_word = (state == ST_MERGE) ? old_q : mem_rd;

  mem_lane_unit u_lane (
    .word_in     (lane_word),
    .offset      (txn.addr[1:0]),
    .size        (txn.size),
    .is_unsigned (txn.is_unsigned),
    .wdata       (txn.wdata),
    .ld_data     (lane_ld),
    .st_word     (lane_st)
  );

  // Request capture and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      txn     <= '0;
      rr_ptr  <= 1'b0;
      rdata_q <= '0;
      old_q   <= '0;
    end else begin
      if (grant) begin
        txn.owner       <= gnt_idx;
        txn.we          <= req_we[gnt_idx];
        txn.size        <= req_size[gnt_idx];
        txn.is_unsigned <= req_unsigned[gnt_idx];
        txn.err         <= access_bad(req_size[gnt_idx], req_addr[gnt_idx][1:0]);
        txn.addr        <= req_addr[gnt_idx];
        txn.wdata       <= req_wdata[gnt_idx];
        rr_ptr          <= ~gnt_idx;
      end
      if (state == ST_ACCESS) begin
        rdata_q <= (!txn.we && !txn.err) ? lane_ld : '0;
        old_q   <= mem_rd;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (grant) state_nxt = ST_ACCESS;
      ST_ACCESS: state_nxt = sub_store ? ST_MERGE : ST_RESP;
      ST_MERGE:  state_nxt = ST_RESP;
      ST_RESP:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Outputs. Everything is forced quiet while rst is high so an abandoned
  // transaction can neither write memory nor respond in the reset cycle.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    rsp_err   = 1'b0;
    rsp_rdata = '0;
    mem_we    = 1'b0;
    mem_a     = '0;
    mem_wd    = '0;
    if (!rst) begin
      case (state)
        ST_IDLE: begin
          if (grant) req_ready[gnt_idx] = 1'b1;
        end
        ST_ACCESS: begin
          mem_a = word_addr;
          if (txn.we && !txn.err && (txn.size == SIZE_WORD)) begin
            mem_we = 1'b1;
            mem_wd = txn.wdata;
          end
        end
        ST_MERGE: begin
          mem_a  = word_addr;
          mem_we = 1'b1;
          mem_wd = lane_st;
        end
        ST_RESP: begin
          rsp_valid[txn.owner] = 1'b1;
          rsp_err              = txn.err;
          rsp_rdata            = rdata_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: directed transactions, a
// transaction-level reference model compared every cycle, and literal
// expectations for the documented scenarios.
module tb_data_mem_ctrl;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       req_valid = '0, req_we = '0, req_unsigned = '0;
  logic [1:0]       req_ready;
  logic [1:0][1:0]  req_size = '0;
  logic [1:0][31:0] req_addr = '0, req_wdata = '0;
  logic [1:0]       rsp_valid;
  logic             rsp_err;
  logic [31:0]      rsp_rdata;
  logic             mem_we;
  logic [31:0]      mem_a, mem_wd, mem_rd;

  logic [31:0] mem    [0:63];
  logic [31:0] shadow [0:63];
  int checks = 0, errors = 0;
  int gq[$];

  always #5 clk = ~clk;

  data_mem_ctrl #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
    .rsp_rdata(rsp_rdata), .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd),
    .mem_rd(mem_rd)
  );

  assign mem_rd = mem[mem_a[7:2]];
  always @(posedge clk) if (mem_we) mem[mem_a[7:2]] = mem_wd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // ---------------- reference model helpers ----------------
  function automatic logic [31:0] ext_load(input logic [31:0] w, input int off, input int sz, input bit uns);
    longint v;
    if (sz == 2) return w;
    if (sz == 0) begin
      v = (w >> (8 * off)) & 32'hFF;
      if (!uns && v >= 128) v = v - 256;
    end else begin
      v = (w >> (8 * off)) & 32'hFFFF;
      if (!uns && v >= 32768) v = v - 65536;
    end
    return v[31:0];
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] w, input int off, input int sz, input logic [31:0] d);
    logic [31:0] m;
    m = (sz == 0) ? 32'hFF : 32'hFFFF;
    m = m << (8 * off);
    return (w & ~m) | ((d << (8 * off)) & m);
  endfunction

  function automatic bit bad(input int sz, input int off);
    return (sz == 3) || (sz == 1 && (off % 2) == 1) || (sz == 2 && off != 0);
  endfunction

  // ---------------- transaction-level model + per-cycle compare ----------------
  int k = 0, m_free = 0, m_rsp_cyc = -1, m_wr_cyc = -1, m_lat, m_sz, m_off;
  bit m_rr = 1'b0, m_owner = 1'b0, m_err = 1'b0, m_g;
  logic [31:0] m_rdata = '0, m_wr_addr = '0, m_wr_data = '0, m_a, m_w;
  logic [1:0] e_ready, e_rsp;
  logic e_we;

  always @(negedge clk) begin
    k++;
    e_ready = '0; e_rsp = '0; e_we = 1'b0;
    if (rst) begin
      m_rr = 1'b0; m_free = k + 1; m_rsp_cyc = -1; m_wr_cyc = -1;
    end else begin
      if (k == m_wr_cyc) begin
        e_we = 1'b1;
        shadow[m_wr_addr[7:2]] = m_wr_data;
      end
      if (k == m_rsp_cyc) e_rsp[m_owner] = 1'b1;
      if (k >= m_free && req_valid != 2'b00) begin
        m_g = req_valid[m_rr] ? m_rr : !m_rr;
        e_ready[m_g] = 1'b1;
        m_rr = !m_g; m_owner = m_g;
        m_a = req_addr[m_g]; m_sz = int'(req_size[m_g]); m_off = int'(m_a[1:0]);
        m_w = shadow[m_a[7:2]];
        m_err = bad(m_sz, m_off); m_rdata = '0; m_lat = 2;
        if (m_err) begin
        end else if (!req_we[m_g]) begin
          m_rdata = ext_load(m_w, m_off, m_sz, req_unsigned[m_g]);
        end else if (m_sz == 2) begin
          m_wr_cyc = k + 1; m_wr_addr = {m_a[31:2], 2'b00}; m_wr_data = req_wdata[m_g];
        end else begin
          m_lat = 3;
          m_wr_cyc = k + 2; m_wr_addr = {m_a[31:2], 2'b00};
          m_wr_data = merge(m_w, m_off, m_sz, req_wdata[m_g]);
        end
        m_rsp_cyc = k + m_lat; m_free = k + m_lat + 1;
      end
    end
    chk("req_ready", 32'(req_ready), 32'(e_ready));
    chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
    chk("mem_we", 32'(mem_we), 32'(e_we));
    chk("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
    if (e_rsp != 2'b00) begin
      chk("rsp_err", 32'(rsp_err), 32'(m_err));
      chk("rsp_rdata", rsp_rdata, m_rdata);
    end
    if (e_we) begin
      chk("mem_a", mem_a, m_wr_addr);
      chk("mem_wd", mem_wd, m_wr_data);
    end
  end

  // ---------------- stimulus ----------------
  task automatic preload(input int idx, input logic [31:0] d);
    mem[idx] = d;
    shadow[idx] = d;
  endtask

  task automatic xfer(input int r, input bit we, input logic [1:0] sz, input bit uns,
                      input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output bit er, output int lat);
    int n;
    rd = '0; er = 1'b0; lat = -1;
    @(posedge clk); #1;
    req_we[r] = we; req_size[r] = sz; req_unsigned[r] = uns;
    req_addr[r] = a; req_wdata[r] = wd; req_valid[r] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready[r] && n < 40) begin @(negedge clk); n++; end
    chk("accept", 32'(req_ready[r]), 32'd1);
    if (!req_ready[r]) begin req_valid[r] = 1'b0; return; end
    gq.push_back(r);
    @(posedge clk); #1;
    // Scramble the inputs after accept; the latched request must be used.
    req_valid[r] = 1'b0; req_addr[r] = ~a; req_wdata[r] = ~wd; req_size[r] = ~sz; req_we[r] = ~we;
    n = 1;
    @(negedge clk);
    while (!rsp_valid[r] && n < 10) begin @(negedge clk); n++; end
    chk("rsp_seen", 32'(rsp_valid[r]), 32'd1);
    rd = rsp_rdata; er = rsp_err; lat = n;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  logic [31:0] rd, rd_a, rd_b, rd_c, rd_d;
  bit er, er_a, er_b, er_c, er_d;
  int lat, lat_a, lat_b, lat_c, lat_d;
  int ord [4];

  initial begin
    int n;
    ord = '{0, 1, 0, 1};
    for (int i = 0; i < 64; i++) begin mem[i] = '0; shadow[i] = '0; end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_mem_wd", mem_wd, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);

    // Word store then load.
    xfer(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, rd, er, lat);
    chk("ws_lat", 32'(lat), 32'd2);
    chk("ws_err", 32'(er), 32'd0);
    chk("ws_mem", mem[4], 32'hDEADBEEF);
    xfer(0, 0, 2'b10, 0, 32'h10, 32'h0, rd, er, lat);
    chk("wl_data", rd, 32'hDEADBEEF);
    chk("wl_lat", 32'(lat), 32'd2);

    // Byte read-modify-write from requester 1.
    preload(8, 32'h11223344);
    xfer(1, 1, 2'b00, 0, 32'h21, 32'h000000AA, rd, er, lat);
    chk("bs_lat", 32'(lat), 32'd3);
    chk("bs_mem", mem[8], 32'h1122AA44);

    // Extension.
    preload(12, 32'h000080F0);
    xfer(0, 0, 2'b01, 0, 32'h30, 0, rd, er, lat); chk("lh_s", rd, 32'hFFFF80F0);
    xfer(0, 0, 2'b01, 1, 32'h30, 0, rd, er, lat); chk("lh_u", rd, 32'h000080F0);
    xfer(1, 0, 2'b00, 0, 32'h30, 0, rd, er, lat); chk("lb_s", rd, 32'hFFFFFFF0);
    xfer(0, 0, 2'b00, 1, 32'h31, 0, rd, er, lat); chk("lb_u1", rd, 32'h00000080);
    xfer(1, 0, 2'b00, 0, 32'h31, 0, rd, er, lat); chk("lb_s1", rd, 32'hFFFFFF80);
    xfer(0, 1, 2'b01, 0, 32'h32, 32'hABCD1234, rd, er, lat);
    chk("hs_lat", 32'(lat), 32'd3);
    chk("hs_mem", mem[12], 32'h123480F0);

    // Misaligned / illegal.
    xfer(0, 1, 2'b10, 0, 32'h13, 32'h12345678, rd, er, lat);
    chk("mis_err", 32'(er), 32'd1);
    chk("mis_lat", 32'(lat), 32'd2);
    chk("mis_mem", mem[4], 32'hDEADBEEF);
    xfer(1, 0, 2'b11, 0, 32'h10, 0, rd, er, lat);
    chk("ill_err", 32'(er), 32'd1);
    chk("ill_data", rd, 32'd0);
    xfer(0, 0, 2'b01, 0, 32'h31, 0, rd, er, lat);
    chk("mish_err", 32'(er), 32'd1);

    // Requester 1 raises and drops valid while the controller is busy.
    fork
      xfer(0, 0, 2'b10, 0, 32'h10, 0, rd, er, lat);
      begin
        @(posedge clk); #1;
        @(posedge clk); #1;
        req_we[1] = 1'b1; req_size[1] = 2'b10; req_addr[1] = 32'h20;
        req_wdata[1] = 32'hBAD0BAD0; req_valid[1] = 1'b1;
        @(posedge clk); #1 req_valid[1] = 1'b0;
      end
    join
    chk("drop_rd", rd, 32'hDEADBEEF);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("drop_mem", mem[8], 32'h1122AA44);

    // Reset while in MERGE.
    preload(9, 32'hCAFEF00D);
    @(posedge clk); #1;
    req_we[1] = 1'b1; req_size[1] = 2'b00; req_unsigned[1] = 1'b0;
    req_addr[1] = 32'h24; req_wdata[1] = 32'h77; req_valid[1] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready[1] && n < 40) begin @(negedge clk); n++; end
    chk("rmo_accept", 32'(req_ready[1]), 32'd1);
    @(posedge clk); #1 req_valid[1] = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("rmo_we", 32'(mem_we), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rmo_mem", mem[9], 32'hCAFEF00D);

    // Contention right after reset: grants must alternate starting with 0.
    gq.delete();
    fork
      begin
        xfer(0, 0, 2'b10, 0, 32'h10, 0, rd_a, er_a, lat_a);
        xfer(0, 0, 2'b10, 0, 32'h10, 0, rd_b, er_b, lat_b);
      end
      begin
        xfer(1, 0, 2'b10, 0, 32'h30, 0, rd_c, er_c, lat_c);
        xfer(1, 0, 2'b10, 0, 32'h30, 0, rd_d, er_d, lat_d);
      end
    join
    chk("con_count", 32'(gq.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk("con_order", (i < gq.size()) ? 32'(gq[i]) : 32'hFFFF, 32'(ord[i]));
    chk("con_rd0", rd_b, 32'hDEADBEEF);
    chk("con_rd1", rd_d, 32'h123480F0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
